// File: rtl/ccd_timing_pkg.sv
// Shared timing definitions for the linear-sensor CCD front end.
// Holds the phase-generator FSM encoding and the default widths and
// exposure constants that the sensor top and the phase generator agree on.
package ccd_timing_pkg;

  // Default geometry of the phase generator.
  localparam int unsigned DEF_N_CH     = 3;
  localparam int unsigned DEF_PW       = 16;
  localparam int unsigned DEF_EW       = 32;
  localparam int unsigned FSEL_W       = 8;

  // Default exposure timing: period = MIN_EXP + f_select * EXP_STEP clk cycles.
  localparam int unsigned DEF_MIN_EXP  = 32'h0018_6A00;
  localparam int unsigned DEF_EXP_STEP = 32'h0000_6429;

  // Run-control states.
  //   ST_IDLE  : outputs quiet, counters parked.
  //   ST_RUN   : free-running line and exposure timing.
  //   ST_DRAIN : run request withdrawn, finishing the current line period.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ccd_state_t;

endpackage : ccd_timing_pkg

// File: rtl/ccd_phase_window.sv
// One CCD phase channel: compares the shared line count against this
// channel's shadowed rise/fall positions and registers the result.
// A rise position above the fall position describes a window that wraps
// through the end of the line (e.g. a 180 degree complementary clock).
// Equal positions give a constant-low output. Positions at or beyond the
// line period are never reached by the counter, so that edge simply never
// happens.
module ccd_phase_window
  import ccd_timing_pkg::*;
#(
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          active,
  input  logic [PW-1:0] cnt,
  input  logic [PW-1:0] rise,
  input  logic [PW-1:0] fall,
  output logic          phi
);

  logic in_window;

  // Window decode for the current line position.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    in_window = 1'b0;
    if (rise < fall) begin
      in_window = (cnt >= rise) && (cnt < fall);
    end else if (rise > fall) begin
      in_window = (cnt >= rise) || (cnt < fall);
    end
  end

  // Output flop: one cycle behind the line count, forced low when inactive.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst) begin
      phi <= 1'b0;
    end else begin
      phi <= active & in_window;
    end
  end

endmodule : ccd_phase_window

// File: rtl/ccd_phase_gen.sv
// CCD clock/phase generator.
// A single line counter drives N_CH programmable phase windows, and an
// independent exposure counter produces the one-clock exposure pulse phi_p.
// Line geometry (period and edge positions) is shadowed at run start and at
// every line wrap, so reprogramming mid-line never produces a runt pulse.
// Dropping enable lets the current line finish before the outputs go quiet.
module ccd_phase_gen
  import ccd_timing_pkg::*;
#(
  parameter int          N_CH     = DEF_N_CH,
  parameter int          PW       = DEF_PW,
  parameter int          EW       = DEF_EW,
  parameter int unsigned MIN_EXP  = DEF_MIN_EXP,
  parameter int unsigned EXP_STEP = DEF_EXP_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PW-1:0]      period,
  input  logic [N_CH*PW-1:0] ch_rise,
  input  logic [N_CH*PW-1:0] ch_fall,
  input  logic [FSEL_W-1:0]  f_select,
  output logic [N_CH-1:0]    phi,
  output logic               phi_p,
  output logic               line_tick,
  output logic               busy
);

  ccd_state_t state;
  ccd_state_t next_state;

  // Line timing: live counter plus the shadow copy of the line geometry.
  logic [PW-1:0]      line_cnt;
  logic [PW-1:0]      per_sh;
  logic [N_CH*PW-1:0] rise_sh;
  logic [N_CH*PW-1:0] fall_sh;

  // Exposure timing: counter plus the shadowed exposure period.
  logic [EW-1:0]      exp_cnt;
  logic [EW-1:0]      exp_sh;

  logic [PW-1:0]      per_eff;
  logic [EW-1:0]      exp_period;
  logic               running;
  logic               start;
  logic               line_last;
  logic               exp_last;
  logic               keep_phi;

  // A line shorter than two cycles cannot hold a rise and a fall, so clamp.
  assign per_eff    = (period < PW'(2)) ? PW'(2) : period;

  // Exposure period at EW bits; overflow is left to the caller's choice of range.
  assign exp_period = EW'(MIN_EXP) + EW'(f_select) * EW'(EXP_STEP);

  assign running    = (state != ST_IDLE);
  assign busy       = running;
  assign start      = (state == ST_IDLE) && enable;
  assign line_last  = (line_cnt == per_sh - PW'(1));
  assign exp_last   = (exp_cnt == exp_sh - EW'(1));

  // Phases are driven only while the FSM stays active into the next cycle,
  // so the last line of a drain ends with all phases low.
  assign keep_phi   = running && (next_state != ST_IDLE);

  // Run-control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Run-control next state: drain finishes the line, re-enable resumes in place.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          // A withdrawal that lands on the last cycle of a line stops at once.
          next_state = line_last ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (enable) begin
          next_state = ST_RUN;
        end else if (line_last) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Line counter and line-geometry shadows, reloaded at start and on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt  <= '0;
      per_sh    <= '0;
      rise_sh   <= '0;
      fall_sh   <= '0;
      line_tick <= 1'b0;
    end else begin
      line_tick <= running && line_last;
      if (start) begin
        line_cnt <= '0;
        per_sh   <= per_eff;
        rise_sh  <= ch_rise;
        fall_sh  <= ch_fall;
      end else if (running) begin
        if (line_last) begin
          line_cnt <= '0;
          per_sh   <= per_eff;
          rise_sh  <= ch_rise;
          fall_sh  <= ch_fall;
        end else begin
          line_cnt <= line_cnt + PW'(1);
        end
      end
    end
  end

  // Exposure counter: frozen in IDLE, exposure period picked up only at its own wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_cnt <= '0;
      exp_sh  <= '0;
      phi_p   <= 1'b0;
    end else begin
      phi_p <= running && exp_last;
      if (start) begin
        exp_cnt <= '0;
        exp_sh  <= exp_period;
      end else if (running) begin
        if (exp_last) begin
          exp_cnt <= '0;
          exp_sh  <= exp_period;
        end else begin
          exp_cnt <= exp_cnt + EW'(1);
        end
      end
    end
  end

  // One window comparator and output flop per phase channel.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ccd_phase_window #(
      .PW(PW)
    ) u_window (
      .clk   (clk),
      .rst   (rst),
      .active(keep_phi),
      .cnt   (line_cnt),
      .rise  (rise_sh[g*PW +: PW]),
      .fall  (fall_sh[g*PW +: PW]),
      .phi   (phi[g])
    );
  end

endmodule : ccd_phase_gen
